// File: rtl/max_unpool.sv
// Max-unpool backward pass: expands one pooled gradient into a WINDOW-beat
// stream, placing the gradient at the argmax position and zeros elsewhere.
module max_unpool #(
    parameter int WINDOW = 4,
    parameter int IDX_W  = $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_grad,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_pos,
    output logic             out_last,
    output logic             err_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WINDOW - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [31:0]      grad_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept;
    logic             beat_done;
    logic             idx_bad;

    assign accept    = in_valid && in_ready;
    assign beat_done = out_valid && out_ready;
    assign idx_bad   = 32'(in_idx) >= 32'(WINDOW);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EMIT;
            EMIT:    if (beat_done && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only registered state, so nothing from in_* reaches out_*.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 32'h0000_0000;
        out_pos   = cnt;
        case (state)
            IDLE: in_ready = 1'b1;
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (cnt == LAST_POS);
                // An out-of-range idx_q never equals cnt, so that window is all zeros.
                if (cnt == idx_q) out_data = grad_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            grad_q  <= 32'h0000_0000;
            idx_q   <= '0;
            err_idx <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            grad_q <= in_grad;
            idx_q  <= in_idx;
            if (idx_bad) err_idx <= 1'b1;
        end else if (beat_done) begin
            // Wrap to zero on the last beat so out_pos idles at 0 for any WINDOW.
            cnt <= out_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_max_unpool.sv
// Scoreboard bench for max_unpool: stimulus pushes expected beats, negedge
// monitors compare every presented beat (stalled or completing) to the queue head.
module tb_max_unpool;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  pos;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v4, r4, or4, ov4, last4, err4;
    logic [31:0] g4, d4;
    logic [1:0]  i4, p4;

    logic        v6, r6, or6, ov6, last6, err6;
    logic [31:0] g6, d6;
    logic [2:0]  i6, p6;

    beat_t q4[$];
    beat_t q6[$];
    logic  rdy_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    max_unpool #(.WINDOW(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4), .in_grad(g4), .in_idx(i4),
        .out_valid(ov4), .out_ready(or4), .out_data(d4), .out_pos(p4),
        .out_last(last4), .err_idx(err4)
    );

    max_unpool #(.WINDOW(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v6), .in_ready(r6), .in_grad(g6), .in_idx(i6),
        .out_valid(ov6), .out_ready(or6), .out_data(d6), .out_pos(p6),
        .out_last(last6), .err_idx(err6)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backpressure pattern for dut4; ready defaults high when the pattern is exhausted.
    always @(posedge clk) begin
        #2;
        or4 = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
    end

    logic done4 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            done4 = 1'b0;
        end else begin
            if (done4) check("idle_after_last4", {r4, ov4}, 2'b10);
            done4 = 1'b0;
            if (ov4) begin
                if (q4.size() == 0) begin
                    check("unexpected_beat4", {d4, 8'(p4), last4}, 0);
                end else begin
                    check("beat4", {d4, 8'(p4), last4}, q4[0]);
                    if (or4) begin
                        done4 = last4;
                        void'(q4.pop_front());
                    end
                end
            end
        end
    end

    logic done6 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            done6 = 1'b0;
        end else begin
            if (done6) check("idle_after_last6", {r6, ov6}, 2'b10);
            done6 = 1'b0;
            if (ov6) begin
                if (q6.size() == 0) begin
                    check("unexpected_beat6", {d6, 8'(p6), last6}, 0);
                end else begin
                    check("beat6", {d6, 8'(p6), last6}, q6[0]);
                    if (or6) begin
                        done6 = last6;
                        void'(q6.pop_front());
                    end
                end
            end
        end
    end

    task automatic send4(input logic [31:0] g, input logic [1:0] idx);
        int n = 0;
        v4 = 1'b1; g4 = g; i4 = idx;
        while (!r4 && n < 200) begin @(posedge clk); #1; n++; end
        if (!r4) check("send4_timeout", 0, 1);
        for (int p = 0; p < 4; p++)
            q4.push_back({(p == int'(idx)) ? g : 32'h0, 8'(p), p == 3});
        @(posedge clk); #1;
        v4 = 1'b0;
    endtask

    task automatic send6(input logic [31:0] g, input logic [2:0] idx);
        int n = 0;
        v6 = 1'b1; g6 = g; i6 = idx;
        while (!r6 && n < 200) begin @(posedge clk); #1; n++; end
        if (!r6) check("send6_timeout", 0, 1);
        for (int p = 0; p < 6; p++)
            q6.push_back({(p == int'(idx)) ? g : 32'h0, 8'(p), p == 5});
        @(posedge clk); #1;
        v6 = 1'b0;
    endtask

    task automatic drain4();
        int n = 0;
        while ((q4.size() != 0 || !r4) && n < 200) begin @(posedge clk); #1; n++; end
        if (q4.size() != 0 || !r4) check("drain4_timeout", 0, 1);
    endtask

    task automatic drain6();
        int n = 0;
        while ((q6.size() != 0 || !r6) && n < 200) begin @(posedge clk); #1; n++; end
        if (q6.size() != 0 || !r6) check("drain6_timeout", 0, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        v4 = 1'b0; g4 = 32'h0; i4 = 2'd0; or4 = 1'b1;
        v6 = 1'b0; g6 = 32'h0; i6 = 3'd0; or6 = 1'b1;
        #12;
        check("reset4", {r4, ov4, d4, p4, last4, err4}, {1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0});
        check("reset6", {r6, ov6, d6, p6, last6, err6}, {1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0});

        // First edge after reset release must accept; out_valid follows one cycle later.
        #10;
        rst_n = 1'b1;
        send4(32'h3FC0_0000, 2'd2);
        check("latency4", {ov4, r4}, 2'b10);
        drain4();

        send4(32'h8000_0000, 2'd0);
        send4(32'h7FC0_0001, 2'd3);
        drain4();

        // Leading 1 is consumed in the idle cycle before acceptance.
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        send4(32'h4120_0000, 2'd1);
        drain4();

        // Input held valid with changing data during EMIT must be ignored.
        send4(32'h4049_0FDB, 2'd1);
        v4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            g4 = 32'hDEAD_0000 + 32'(k);
            i4 = 2'(k);
            check("no_accept_in_emit", {30'h0, r4, ov4}, 2'b01);
            @(posedge clk); #1;
        end
        send4(32'hC000_0000, 2'd3);
        drain4();

        // Asynchronous reset in the middle of beat 2 aborts the window.
        send4(32'h3F80_0000, 2'd3);
        n = 0;
        while (p4 != 2'd2 && n < 20) begin @(posedge clk); #1; n++; end
        check("reach_beat2", {30'h0, p4}, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset4", {r4, ov4, d4, p4, last4, err4}, {1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0});
        q4.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_beats", {r4, ov4}, 2'b10);
        send4(32'h0000_0001, 2'd2);
        drain4();

        // WINDOW=6: out-of-range index gives all zeros and a sticky error.
        check("err6_clear", err6, 0);
        send6(32'h1234_5678, 3'd7);
        check("err6_set", err6, 1);
        drain6();
        send6(32'hBF80_0000, 3'd5);
        drain6();
        check("err6_sticky", err6, 1);
        check("err4_clear", err4, 0);

        check("q4_empty", q4.size(), 0);
        check("q6_empty", q6.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/max_unpool.md
MAX_UNPOOL -- requirements
Module: max_unpool

Interface
REQ-001 SHALL have parameter WINDOW, default 4: number of elements per pooling window, legal range 2..256.
REQ-002 SHALL have parameter IDX_W, default $clog2(WINDOW): width of the argmax index.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: in_grad and in_idx are valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts an input this cycle.
REQ-007 SHALL have port in_grad, input, 32: IEEE-754 single-precision gradient of the pooled max output.
REQ-008 SHALL have port in_idx, input, IDX_W: window position that won the forward max.
REQ-009 SHALL have port out_valid, output, 1: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1: the downstream consumer accepts out_data.
REQ-011 SHALL have port out_data, output, 32: FP32 gradient for window position out_pos.
REQ-012 SHALL have port out_pos, output, IDX_W: window position of the current out_data.
REQ-013 SHALL have port out_last, output, 1: the current beat is window position WINDOW-1.
REQ-014 SHALL have port err_idx, output, 1: sticky flag, set when an out-of-range index is accepted.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in EMIT, in_ready SHALL be 0.
REQ-017 An input is accepted on a rising edge with in_valid=1 and in_ready=1. On acceptance the block SHALL latch in_grad and in_idx, set the beat counter to 0, and enter EMIT.
REQ-018 Latency: out_valid SHALL be 1 in the first cycle after the acceptance edge.
REQ-019 In EMIT, out_valid SHALL be 1 and out_pos SHALL equal the beat counter.
REQ-020 In EMIT, out_data SHALL equal the latched gradient bit-exact when the counter equals the latched index, and 32'h0000_0000 otherwise.
REQ-021 The gradient SHALL pass through unmodified, including sign, -0.0, denormals, Inf and NaN payloads; no arithmetic is performed on it.
REQ-022 out_last SHALL be 1 exactly when the block is in EMIT and the counter equals WINDOW-1.
REQ-023 A beat completes when out_valid=1 and out_ready=1 on a rising edge. On completion the counter SHALL increment; on completion of the out_last beat the FSM SHALL return to IDLE.
REQ-024 With out_ready=0, out_data, out_pos and out_last SHALL hold stable and out_valid SHALL stay 1 (no beat dropped or repeated).
REQ-025 A window SHALL occupy exactly WINDOW completed beats. Peak throughput SHALL be one window per WINDOW+1 cycles.
REQ-026 If the accepted index is >= WINDOW, all WINDOW beats SHALL be 32'h0 and err_idx SHALL set on the acceptance edge.
REQ-027 err_idx SHALL remain set until reset.
REQ-028 in_valid asserted while in EMIT SHALL NOT be accepted and SHALL NOT disturb the latched data.
REQ-029 All outputs SHALL be driven from registers or from state-only decode; there SHALL be no combinational path from in_* to out_*.

Reset
REQ-030 On rst_n=0, regardless of clock, the block SHALL immediately enter IDLE with: counter=0, latched grad=0, latched idx=0, out_valid=0, out_data=0, out_pos=0, out_last=0, err_idx=0, in_ready=1.
REQ-031 Reset asserted mid-window SHALL abort the window. No further beats of that window SHALL be emitted after rst_n rises.
REQ-032 The first acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-033 WINDOW=4, in_grad=32'h3FC0_0000, in_idx=2, out_ready=1 -> out_data sequence 0, 0, 3FC0_0000, 0; out_pos 0..3; out_last only on beat 3; in_ready returns to 1 one cycle after beat 3.
REQ-034 in_grad=32'h8000_0000 at idx 0, then in_grad=32'h7FC0_0001 at idx 3 -> beat 0 is 8000_0000 and beat 3 is 7FC0_0001 bit-exact; all other beats are 0.
REQ-035 Backpressure: idx=1, out_ready toggles 0,0,1,0,1,1,1 -> exactly 4 beats complete, values stable while stalled, no beat lost or duplicated.
REQ-036 WINDOW=6, in_idx=7 -> six zero beats; err_idx rises on the acceptance edge and stays 1 through a subsequent legal window.
REQ-037 rst_n pulsed low during beat 2 of 4 -> all outputs are 0 asynchronously, in_ready=1, and the next accepted window emits a complete 4-beat sequence.
REQ-038 in_valid held 1 with changing data during EMIT -> only the first value is emitted, and the next input is accepted only in IDLE.
